// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and encodings for the write-back arbiter
package rf_wb_arbiter_pkg;

    localparam int DEF_REG_DATA_WIDTH  = 32;
    localparam int DEF_REG_CODE_LENGTH = 5;
    localparam int DEF_REG_DEPTH       = 32;
    localparam int DEF_WB_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT    = 4;

    typedef enum logic {
        WB_NORMAL = 1'b0,
        WB_DRAIN  = 1'b1
    } wb_state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MC  = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - result, issue, hazard-query and register-file write bundle
interface rf_wb_arbiter_if #(
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_CODE_LENGTH = 5
);
    logic                       alu_valid;
    logic [REG_CODE_LENGTH-1:0] alu_rd;
    logic [REG_DATA_WIDTH-1:0]  alu_data;
    logic                       mc_valid;
    logic                       mc_ready;
    logic [REG_CODE_LENGTH-1:0] mc_rd;
    logic [REG_DATA_WIDTH-1:0]  mc_data;
    logic                       iss_valid;
    logic [REG_CODE_LENGTH-1:0] iss_rd;
    logic                       iss_ready;
    logic [REG_CODE_LENGTH-1:0] chk_rs1;
    logic [REG_CODE_LENGTH-1:0] chk_rs2;
    logic [REG_CODE_LENGTH-1:0] chk_rd;
    logic                       busy_rs1;
    logic                       busy_rs2;
    logic                       busy_rd;
    logic                       wb_stall;
    logic                       RegWrite;
    logic [REG_CODE_LENGTH-1:0] w_rg;
    logic [REG_DATA_WIDTH-1:0]  w_data;

    modport master (
        output alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
        output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
        input  mc_ready, iss_ready, busy_rs1, busy_rs2, busy_rd,
        input  wb_stall, RegWrite, w_rg, w_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mc_valid, mc_rd, mc_data,
        input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
        output mc_ready, iss_ready, busy_rs1, busy_rs2, busy_rd,
        output wb_stall, RegWrite, w_rg, w_data
    );
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// rtl/rf_wb_arbiter_wb_fifo.sv - synchronous FIFO, no fall-through, wrap bit on pointers
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: pointer reset alone discards stale entries.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges ALU and buffered multi-cycle results onto the register-file write port
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int REG_DATA_WIDTH  = DEF_REG_DATA_WIDTH,
    parameter int REG_CODE_LENGTH = DEF_REG_CODE_LENGTH,
    parameter int REG_DEPTH       = DEF_REG_DEPTH,
    parameter int WB_FIFO_DEPTH   = DEF_WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int EW = REG_CODE_LENGTH + REG_DATA_WIDTH;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       alu_win;
    logic                       do_push;
    logic                       do_pop;
    logic [EW-1:0]              head;
    logic [REG_CODE_LENGTH-1:0] head_rd;
    logic [REG_DATA_WIDTH-1:0]  head_data;
    logic [REG_DEPTH-1:0]       busy;
    logic                       iss_set;
    logic                       mc_clear;
    wb_src_t                    src_q;
    wb_state_t                  state;
    wb_state_t                  state_next;
    logic [CW-1:0]              starve_cnt;
    logic [CW-1:0]              starve_next;

    assign alu_win      = bus.alu_valid && (bus.alu_rd != '0);
    assign bus.mc_ready = !fifo_full;
    assign do_push      = bus.mc_valid && !fifo_full;
    assign do_pop       = !alu_win && !fifo_empty;
    assign head_rd      = head[EW-1:REG_DATA_WIDTH];
    assign head_data    = head[REG_DATA_WIDTH-1:0];

    wb_fifo #(.WIDTH(EW), .DEPTH(WB_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .push_data ({bus.mc_rd, bus.mc_data}),
        .pop       (do_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // x0 results still drain from the buffer but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWrite <= 1'b0;
            bus.w_rg     <= '0;
            bus.w_data   <= '0;
            src_q        <= SRC_ALU;
        end else if (alu_win) begin
            bus.RegWrite <= 1'b1;
            bus.w_rg     <= bus.alu_rd;
            bus.w_data   <= bus.alu_data;
            src_q        <= SRC_ALU;
        end else if (do_pop) begin
            bus.RegWrite <= (head_rd != '0);
            bus.w_rg     <= head_rd;
            bus.w_data   <= head_data;
            src_q        <= SRC_MC;
        end else begin
            bus.RegWrite <= 1'b0;
        end
    end

    // Busy clears on the same edge the register file captures the value.
    assign iss_set  = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);
    assign mc_clear = bus.RegWrite && (src_q == SRC_MC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            if (mc_clear)
                busy[bus.w_rg] <= 1'b0;
            if (iss_set)
                busy[bus.iss_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign bus.iss_ready = !busy[bus.iss_rd];
    assign bus.busy_rs1  = busy[bus.chk_rs1];
    assign bus.busy_rs2  = busy[bus.chk_rs2];
    assign bus.busy_rd   = busy[bus.chk_rd];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WB_NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            WB_NORMAL: begin
                if (do_pop) begin
                    starve_next = '0;
                end else if (alu_win && !fifo_empty) begin
                    starve_next = starve_cnt + CW'(1);
                    if (starve_next == CW'(STARVE_LIMIT))
                        state_next = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if (do_pop) begin
                    state_next  = WB_NORMAL;
                    starve_next = '0;
                end
            end
            default: state_next = WB_NORMAL;
        endcase
    end

    always_comb begin
        bus.wb_stall = (state == WB_DRAIN);
    end

    alu_write_to_busy: assert property (@(posedge clk) disable iff (!rst)
        !(alu_win && busy[bus.alu_rd]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int CW = 5;
    localparam int RD = 32;
    localparam int FD = 4;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.REG_DATA_WIDTH(DW), .REG_CODE_LENGTH(CW)) bus ();

    rf_wb_arbiter #(
        .REG_DATA_WIDTH(DW), .REG_CODE_LENGTH(CW), .REG_DEPTH(RD),
        .WB_FIFO_DEPTH(FD), .STARVE_LIMIT(SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [CW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    bit            mbusy [RD];
    bit            m_we;
    bit            m_src;
    bit            m_drain;
    logic [CW-1:0] m_rg;
    logic [DW-1:0] m_data;
    int            m_cnt;

    task automatic model_reset();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_we = 0; m_src = 0; m_drain = 0; m_rg = '0; m_data = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit   alu_win, do_pop, do_push, do_iss;
        int   sz;
        ent_t h, n;
        alu_win = bus.alu_valid && (bus.alu_rd != 0);
        sz      = mq.size();
        do_pop  = !alu_win && (sz > 0);
        do_push = bus.mc_valid && (sz < FD);
        do_iss  = bus.iss_valid && (bus.iss_rd != 0) && !mbusy[bus.iss_rd];
        if (m_we && m_src) mbusy[m_rg] = 1'b0;
        if (do_iss) mbusy[bus.iss_rd] = 1'b1;
        if (alu_win) begin
            m_we = 1; m_rg = bus.alu_rd; m_data = bus.alu_data; m_src = 0;
        end else if (do_pop) begin
            h = mq.pop_front();
            m_we = (h.rd != 0); m_rg = h.rd; m_data = h.data; m_src = 1;
        end else begin
            m_we = 0;
        end
        if (do_push) begin
            n.rd = bus.mc_rd; n.data = bus.mc_data;
            mq.push_back(n);
        end
        if (!m_drain) begin
            if (do_pop) m_cnt = 0;
            else if (alu_win && sz > 0) m_cnt++;
            if (m_cnt >= SL) m_drain = 1;
        end else if (do_pop) begin
            m_drain = 0; m_cnt = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    always @(negedge clk) begin
        chk("regwrite", bus.RegWrite, m_we);
        if (m_we) begin
            chk("w_rg", bus.w_rg, m_rg);
            chk("w_data", bus.w_data, m_data);
        end
        chk("mc_ready", bus.mc_ready, mq.size() < FD);
        chk("wb_stall", bus.wb_stall, m_drain);
        chk("busy_rs1", bus.busy_rs1, mbusy[bus.chk_rs1]);
        chk("busy_rs2", bus.busy_rs2, mbusy[bus.chk_rs2]);
        chk("busy_rd", bus.busy_rd, mbusy[bus.chk_rd]);
        chk("iss_ready", bus.iss_ready, !mbusy[bus.iss_rd]);
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.mc_valid = 0; bus.iss_valid = 0;
    endtask

    initial begin
        idle();
        bus.alu_rd = '0; bus.alu_data = '0; bus.mc_rd = '0; bus.mc_data = '0;
        bus.iss_rd = '0; bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;

        // reset held with a pending multi-cycle result
        bus.mc_valid = 1; bus.mc_rd = 5'd3; bus.mc_data = 32'h55; bus.chk_rs1 = 5'd3;
        next(); next();
        chk("rst_regwrite", bus.RegWrite, 1'b0);
        chk("rst_mc_ready", bus.mc_ready, 1'b1);
        chk("rst_busy", bus.busy_rs1, 1'b0);
        bus.mc_valid = 0;
        rst = 1;
        next();
        chk("rst_stall", bus.wb_stall, 1'b0);

        // ALU path, then an x0 destination
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        next();
        chk("alu_we", bus.RegWrite, 1'b1);
        chk("alu_rg", bus.w_rg, 5'd5);
        chk("alu_data", bus.w_data, 32'hDEADBEEF);
        bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
        next();
        chk("alu_x0_we", bus.RegWrite, 1'b0);
        idle();

        // scoreboard lifetime of x7
        bus.iss_valid = 1; bus.iss_rd = 5'd7; bus.chk_rs1 = 5'd7;
        next();
        bus.iss_valid = 0; #1;
        chk("sb_busy_set", bus.busy_rs1, 1'b1);
        chk("sb_iss_ready", bus.iss_ready, 1'b0);
        next();
        bus.mc_valid = 1; bus.mc_rd = 5'd7; bus.mc_data = 32'h1234;
        next();
        bus.mc_valid = 0;
        chk("sb_busy_push", bus.busy_rs1, 1'b1);
        next();
        chk("sb_we", bus.RegWrite, 1'b1);
        chk("sb_rg", bus.w_rg, 5'd7);
        chk("sb_data", bus.w_data, 32'h1234);
        chk("sb_busy_wr", bus.busy_rs1, 1'b1);
        next();
        chk("sb_busy_clr", bus.busy_rs1, 1'b0);
        chk("sb_iss_ready_clr", bus.iss_ready, 1'b1);

        // fill under continuous ALU traffic, then starvation drain
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h100 + i;
            bus.mc_valid = 1; bus.mc_rd = 5'(10 + i); bus.mc_data = 32'(i);
            next();
        end
        bus.mc_valid = 0; #1;
        chk("full_ready", bus.mc_ready, 1'b0);
        chk("pre_stall", bus.wb_stall, 1'b0);
        next();
        chk("starve_stall", bus.wb_stall, 1'b1);
        next();
        chk("drain_alu_wins", bus.w_rg, 5'd1);
        chk("drain_hold", bus.wb_stall, 1'b1);
        bus.alu_valid = 0;
        next();
        chk("drain_pop_rg", bus.w_rg, 5'd10);
        chk("drain_pop_data", bus.w_data, 32'h0);
        chk("drain_exit", bus.wb_stall, 1'b0);

        // stream six more entries through to wrap the pointers, one to x0
        for (int i = 0; i < 6; i++) begin
            bus.mc_valid = 1; bus.mc_rd = (i == 2) ? 5'd0 : 5'(20 + i); bus.mc_data = 32'hA000 + i;
            next();
        end
        bus.mc_valid = 0;
        repeat (6) next();

        // full while the head pops: no push that cycle
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h200 + i;
            bus.mc_valid = 1; bus.mc_rd = 5'(3 + i); bus.mc_data = 32'hC0 + i;
            next();
        end
        bus.alu_valid = 0;
        bus.mc_valid = 1; bus.mc_rd = 5'd9; bus.mc_data = 32'hBAD; #1;
        chk("fullpop_ready", bus.mc_ready, 1'b0);
        next();
        chk("fullpop_after", bus.mc_ready, 1'b1);
        next();
        bus.mc_valid = 0;
        repeat (6) next();

        // asynchronous reset with buffered entries and busy registers
        bus.iss_valid = 1; bus.iss_rd = 5'd8;
        next();
        bus.iss_rd = 5'd9;
        next();
        bus.iss_valid = 0; bus.chk_rs1 = 5'd8; bus.chk_rs2 = 5'd9;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h300 + i;
            bus.mc_valid = 1; bus.mc_rd = 5'(3 + i); bus.mc_data = 32'hE0 + i;
            next();
        end
        bus.mc_valid = 0;
        chk("pre_rst_we", bus.RegWrite, 1'b1);
        chk("pre_rst_busy", bus.busy_rs2, 1'b1);
        #1 rst = 0; bus.alu_valid = 0;
        #1;
        chk("arst_we", bus.RegWrite, 1'b0);
        chk("arst_rg", bus.w_rg, 5'd0);
        chk("arst_data", bus.w_data, 32'h0);
        chk("arst_busy1", bus.busy_rs1, 1'b0);
        chk("arst_busy2", bus.busy_rs2, 1'b0);
        chk("arst_ready", bus.mc_ready, 1'b1);
        next();
        rst = 1;
        repeat (3) next();
        chk("post_rst_we", bus.RegWrite, 1'b0);
        chk("post_rst_ready", bus.mc_ready, 1'b1);
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
